// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the multiplier arbiter
//
// Purpose: opcode encodings, per-pipe state enum, in-flight record and the
// opcode-to-word-select helper used by the arbiter and its interface.
// Ports: none (package).

package mul_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] MUL_OP_W  = 2'b00;
  localparam logic [1:0] MUL_OP_H  = 2'b01;
  localparam logic [1:0] MUL_OP_HU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic valid;
    logic pipe;
    logic hi_sel;
  } inflight_t;

  // High word for both MULH variants; MUL.W and the reserved code take the low word.
  function automatic logic op_hi_sel(input logic [1:0] op);
    logic hi;
    case (op)
      MUL_OP_W:            hi = 1'b0;
      MUL_OP_H, MUL_OP_HU: hi = 1'b1;
      default:             hi = 1'b0;
    endcase
    return hi;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - pipe request/response and multiplier handshake bundle
//
// Purpose: groups the two pipes' request/response channels and the shared
// multiplier's launch/product signals.
// Ports (index [p] = pipe 0/1):
//   req_valid/req_op/req_src1/req_src2 -> arbiter, req_ready <- arbiter
//   resp_valid/resp_data <- arbiter, resp_ready -> arbiter
//   mul_start/mul_signed/mul_a/mul_b <- arbiter, mul_done/mul_result -> arbiter
// Modports: slave = arbiter side, master = pipes + multiplier side.

interface mul_arbiter_if;
  import mul_pkg::*;

  logic [1:0]              req_valid;
  logic [1:0][1:0]         req_op;
  logic [1:0][DATA_W-1:0]  req_src1;
  logic [1:0][DATA_W-1:0]  req_src2;
  logic [1:0]              req_ready;

  logic [1:0]              resp_valid;
  logic [1:0][DATA_W-1:0]  resp_data;
  logic [1:0]              resp_ready;

  logic                    mul_start;
  logic                    mul_signed;
  logic [DATA_W-1:0]       mul_a;
  logic [DATA_W-1:0]       mul_b;
  logic                    mul_done;
  logic [2*DATA_W-1:0]     mul_result;

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, resp_ready, mul_done, mul_result,
    output req_ready, resp_valid, resp_data, mul_start, mul_signed, mul_a, mul_b
  );

  modport master (
    output req_valid, req_op, req_src1, req_src2, resp_ready, mul_done, mul_result,
    input  req_ready, resp_valid, resp_data, mul_start, mul_signed, mul_a, mul_b
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter
//
// Purpose: one-hot grant from a 2-bit eligible vector; the preference
// pointer flips to the other requester after every grant.
// Ports:
//   clk, rst  clock, synchronous active-high reset (pointer -> 0)
//   eligible  in  [1:0] requesters able to be granted this cycle
//   grant     out [1:0] one-hot grant (combinational), 0 when none eligible

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic rr_ptr;

  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (|grant) begin
      rr_ptr <= ~grant[1];
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - shares one pipelined multiplier between two execute pipes
//
// Purpose: round-robin grants of pipe multiply requests onto the multiplier,
// tracks the single in-flight operation, picks low/high product word and
// holds one result per pipe until the pipe takes it. flush drops all work.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   flush     kills pending, in-flight and buffered responses
//   bus       mul_arbiter_if.slave (pipe request/response, multiplier drive)

module mul_arbiter
  import mul_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  mul_arbiter_if.slave   bus
);

  pipe_state_e             state_q [2];
  pipe_state_e             state_d [2];
  inflight_t               infl_q;
  inflight_t               infl_d;
  logic [1:0][DATA_W-1:0]  buf_q;

  logic [1:0]              eligible;
  logic [1:0]              grant;
  logic                    any_grant;
  logic                    gnt_idx;
  logic                    capture;
  logic [DATA_W-1:0]       cap_word;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      eligible[p] = bus.req_valid[p] && (state_q[p] == IDLE) && !flush && !rst;
    end
  end

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .grant    (grant)
  );

  assign any_grant = |grant;
  assign gnt_idx   = grant[1];

  // A product arriving with nothing tracked, or during flush/reset, is dropped.
  assign capture  = bus.mul_done && infl_q.valid && !flush && !rst;
  assign cap_word = infl_q.hi_sel ? bus.mul_result[2*DATA_W-1:DATA_W]
                                  : bus.mul_result[DATA_W-1:0];

  always_comb begin
    bus.req_ready  = grant;
    bus.mul_start  = any_grant;
    bus.mul_a      = '0;
    bus.mul_b      = '0;
    bus.mul_signed = 1'b0;
    if (any_grant) begin
      bus.mul_a      = bus.req_src1[gnt_idx];
      bus.mul_b      = bus.req_src2[gnt_idx];
      bus.mul_signed = (bus.req_op[gnt_idx] != MUL_OP_HU);
    end
  end

  // A grant in the same cycle as a completion overwrites the entry; the
  // completing product has already been steered by the old entry.
  always_comb begin
    infl_d = infl_q;
    if (flush) begin
      infl_d = '0;
    end else if (any_grant) begin
      infl_d.valid  = 1'b1;
      infl_d.pipe   = gnt_idx;
      infl_d.hi_sel = op_hi_sel(bus.req_op[gnt_idx]);
    end else if (capture) begin
      infl_d = '0;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      if (flush) begin
        state_d[p] = IDLE;
      end else begin
        case (state_q[p])
          IDLE: if (grant[p]) state_d[p] = BUSY;
          BUSY: if (capture && (infl_q.pipe == 1'(p))) state_d[p] = HOLD;
          HOLD: if (bus.resp_ready[p]) state_d[p] = IDLE;
          default: state_d[p] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
      infl_q     <= '0;
      buf_q      <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      infl_q     <= infl_d;
      if (capture) begin
        buf_q[infl_q.pipe] <= cap_word;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      bus.resp_valid[p] = (state_q[p] == HOLD);
    end
    bus.resp_data = buf_q;
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - self-checking bench for mul_arbiter

module tb_mul_arbiter;
  import mul_pkg::*;

  logic clk;
  logic rst;
  logic flush;

  mul_arbiter_if bus ();

  mul_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: product one cycle after start.
  logic        mul_done_r = 1'b0;
  logic [63:0] prod_r     = '0;

  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  always @(posedge clk) begin
    mul_done_r <= bus.mul_start;
    if (bus.mul_start) prod_r <= model_mul(bus.mul_a, bus.mul_b, bus.mul_signed);
  end

  assign bus.mul_done   = mul_done_r;
  assign bus.mul_result = prod_r;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  rready;
    logic [1:0]  e_rdy;
    logic        e_start;
    logic        e_signed;
    logic [31:0] e_a;
    logic [1:0]  e_rv;
    logic [31:0] e_d0, e_d1;
  } vec_t;

  function automatic vec_t mk(logic [1:0] valid, logic [1:0] op0, logic [1:0] op1,
                              logic [31:0] a0, logic [31:0] b0, logic [31:0] a1,
                              logic [31:0] b1, logic [1:0] rready, logic [1:0] e_rdy,
                              logic e_start, logic e_signed, logic [31:0] e_a,
                              logic [1:0] e_rv, logic [31:0] e_d0, logic [31:0] e_d1);
    vec_t v;
    v.valid = valid; v.op0 = op0; v.op1 = op1;
    v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1; v.rready = rready;
    v.e_rdy = e_rdy; v.e_start = e_start; v.e_signed = e_signed; v.e_a = e_a;
    v.e_rv = e_rv; v.e_d0 = e_d0; v.e_d1 = e_d1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] valid, input logic [1:0] op0, input logic [1:0] op1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [1:0] rready);
    bus.req_valid   = valid;
    bus.req_op[0]   = op0;
    bus.req_op[1]   = op1;
    bus.req_src1[0] = a0;
    bus.req_src2[0] = b0;
    bus.req_src1[1] = a1;
    bus.req_src2[1] = b1;
    bus.resp_ready  = rready;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
    flush = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  vec_t vecs [15];

  initial begin
    //            valid  op0    op1    a0           b0 a1           b1  rr     rdy    st sg e_a          rv     d0           d1
    vecs[0]  = mk(2'b00, 2'b00, 2'b00, 0,           0, 0,           0,  2'b00, 2'b00, 0, 0, 0,           2'b00, 0,           0);
    vecs[1]  = mk(2'b01, 2'b00, 2'b00, 32'hFFFFFFFF, 2, 0,           0,  2'b11, 2'b01, 1, 1, 32'hFFFFFFFF, 2'b00, 0,           0);
    vecs[2]  = mk(2'b00, 2'b00, 2'b00, 0,           0, 0,           0,  2'b11, 2'b00, 0, 0, 0,           2'b00, 0,           0);
    vecs[3]  = mk(2'b10, 2'b00, 2'b01, 0,           0, 32'hFFFFFFFF, 2, 2'b11, 2'b10, 1, 1, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE, 0);
    vecs[4]  = mk(2'b00, 2'b00, 2'b00, 0,           0, 0,           0,  2'b11, 2'b00, 0, 0, 0,           2'b00, 0,           0);
    vecs[5]  = mk(2'b10, 2'b00, 2'b10, 0,           0, 32'hFFFFFFFF, 2, 2'b11, 2'b00, 0, 0, 0,           2'b10, 0,           32'hFFFFFFFF);
    vecs[6]  = mk(2'b10, 2'b00, 2'b10, 0,           0, 32'hFFFFFFFF, 2, 2'b11, 2'b10, 1, 0, 32'hFFFFFFFF, 2'b00, 0,           0);
    vecs[7]  = mk(2'b00, 2'b00, 2'b00, 0,           0, 0,           0,  2'b11, 2'b00, 0, 0, 0,           2'b00, 0,           0);
    vecs[8]  = mk(2'b00, 2'b00, 2'b00, 0,           0, 0,           0,  2'b11, 2'b00, 0, 0, 0,           2'b10, 0,           32'h00000001);
    vecs[9]  = mk(2'b11, 2'b00, 2'b00, 3,           5, 7,           11, 2'b11, 2'b01, 1, 1, 3,           2'b00, 0,           0);
    vecs[10] = mk(2'b11, 2'b00, 2'b00, 3,           5, 7,           11, 2'b11, 2'b10, 1, 1, 7,           2'b00, 0,           0);
    vecs[11] = mk(2'b11, 2'b00, 2'b00, 3,           5, 7,           11, 2'b11, 2'b00, 0, 0, 0,           2'b01, 15,          0);
    vecs[12] = mk(2'b11, 2'b00, 2'b00, 3,           5, 7,           11, 2'b11, 2'b01, 1, 1, 3,           2'b10, 0,           77);
    vecs[13] = mk(2'b11, 2'b00, 2'b00, 3,           5, 7,           11, 2'b11, 2'b10, 1, 1, 7,           2'b00, 0,           0);
    vecs[14] = mk(2'b11, 2'b00, 2'b00, 3,           5, 7,           11, 2'b11, 2'b00, 0, 0, 0,           2'b01, 15,          0);

    rst   = 1'b1;
    flush = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 15; i++) begin
      tick();
      rst = 1'b0;
      drive(vecs[i].valid, vecs[i].op0, vecs[i].op1, vecs[i].a0, vecs[i].b0,
            vecs[i].a1, vecs[i].b1, vecs[i].rready);
      #1;
      chk($sformatf("v%0d_req_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d_mul_start", i), 64'(bus.mul_start), 64'(vecs[i].e_start));
      chk($sformatf("v%0d_mul_signed", i), 64'(bus.mul_signed), 64'(vecs[i].e_signed));
      chk($sformatf("v%0d_mul_a", i), 64'(bus.mul_a), 64'(vecs[i].e_a));
      chk($sformatf("v%0d_resp_valid", i), 64'(bus.resp_valid), 64'(vecs[i].e_rv));
      if (vecs[i].e_rv[0] || i == 0)
        chk($sformatf("v%0d_resp_data0", i), 64'(bus.resp_data[0]), 64'(vecs[i].e_d0));
      if (vecs[i].e_rv[1] || i == 0)
        chk($sformatf("v%0d_resp_data1", i), 64'(bus.resp_data[1]), 64'(vecs[i].e_d1));
    end

    // Pipe0 stalls its response for 5 cycles while pipe1 keeps issuing.
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 6, 7, 2, 3, 2'b10);
    #1;
    chk("stall_grant0", 64'(bus.req_ready), 64'(2'b01));
    tick();
    #1;
    chk("stall_grant1", 64'(bus.req_ready), 64'(2'b10));
    for (int k = 2; k <= 6; k++) begin
      tick();
      #1;
      chk($sformatf("stall_k%0d_rv0", k), 64'(bus.resp_valid[0]), 64'(1'b1));
      chk($sformatf("stall_k%0d_d0", k), 64'(bus.resp_data[0]), 64'd42);
      chk($sformatf("stall_k%0d_req_ready", k), 64'(bus.req_ready),
          (k == 4) ? 64'(2'b10) : 64'(2'b00));
    end
    tick();
    bus.resp_ready = 2'b11;
    #1;
    chk("stall_release_rv0", 64'(bus.resp_valid[0]), 64'(1'b1));
    chk("stall_release_d0", 64'(bus.resp_data[0]), 64'd42);
    chk("stall_release_req_ready", 64'(bus.req_ready), 64'(2'b10));
    tick();
    #1;
    chk("stall_after_rv0", 64'(bus.resp_valid[0]), 64'(1'b0));
    chk("stall_after_req_ready", 64'(bus.req_ready), 64'(2'b01));

    // Flush the cycle after a grant: that product never shows up.
    do_reset();
    drive(2'b01, 2'b00, 2'b00, 9, 9, 0, 0, 2'b11);
    #1;
    chk("flush_grant", 64'(bus.req_ready), 64'(2'b01));
    tick();
    flush = 1'b1;
    drive(2'b01, 2'b00, 2'b00, 4, 5, 0, 0, 2'b11);
    #1;
    chk("flush_no_grant", 64'(bus.req_ready), 64'(2'b00));
    chk("flush_no_start", 64'(bus.mul_start), 64'(1'b0));
    chk("flush_rv_a", 64'(bus.resp_valid), 64'(2'b00));
    tick();
    flush = 1'b0;
    #1;
    chk("flush_regrant", 64'(bus.req_ready), 64'(2'b01));
    chk("flush_rv_b", 64'(bus.resp_valid), 64'(2'b00));
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("flush_rv_c", 64'(bus.resp_valid), 64'(2'b00));
    tick();
    #1;
    chk("flush_new_rv", 64'(bus.resp_valid), 64'(2'b01));
    chk("flush_new_d0", 64'(bus.resp_data[0]), 64'd20);

    // Reset while pipe1 holds a response.
    do_reset();
    drive(2'b10, 2'b00, 2'b00, 0, 0, 5, 5, 2'b00);
    #1;
    chk("rst_grant1", 64'(bus.req_ready), 64'(2'b10));
    tick();
    bus.req_valid = 2'b00;
    tick();
    drive(2'b01, 2'b00, 2'b00, 1, 1, 0, 0, 2'b00);
    #1;
    chk("rst_hold_rv1", 64'(bus.resp_valid), 64'(2'b10));
    chk("rst_hold_d1", 64'(bus.resp_data[1]), 64'd25);
    chk("rst_hold_grant0", 64'(bus.req_ready), 64'(2'b01));
    tick();
    rst = 1'b1;
    #1;
    chk("rst_pre_ptr", 64'(dut.u_arb.rr_ptr), 64'(1'b1));
    chk("rst_cycle_no_grant", 64'(bus.req_ready), 64'(2'b00));
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    chk("rst_after_rv", 64'(bus.resp_valid), 64'(2'b00));
    chk("rst_after_ptr", 64'(dut.u_arb.rr_ptr), 64'(1'b0));
    chk("rst_after_d0", 64'(bus.resp_data[0]), 64'd0);
    chk("rst_after_d1", 64'(bus.resp_data[1]), 64'd0);
    chk("rst_after_st0", 64'(dut.state_q[0]), 64'(IDLE));
    chk("rst_after_st1", 64'(dut.state_q[1]), 64'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
